// File: rtl/affine_iter_ctrl_if.sv
// Handshake bundle for affine_iter_ctrl: the issue/result pair towards the
// affine_transform datapath and the valid/ready stream towards the keystream stage.
interface affine_iter_ctrl_if #(
  parameter int unsigned PRECISION = 32
);

  // Datapath side
  logic                   at_tvalid;
  logic [9*PRECISION-1:0] at_A;
  logic [3*PRECISION-1:0] at_U;
  logic [3*PRECISION-1:0] at_x;
  logic                   at_valid;
  logic [3*PRECISION-1:0] at_x_next;

  // Output stream side
  logic                   m_tvalid;
  logic                   m_tready;
  logic [3*PRECISION-1:0] m_tdata;
  logic                   m_tlast;

  // Controller view
  modport master (
    output at_tvalid, at_A, at_U, at_x, m_tvalid, m_tdata, m_tlast,
    input  at_valid, at_x_next, m_tready
  );

  // Datapath / downstream view
  modport slave (
    input  at_tvalid, at_A, at_U, at_x, m_tvalid, m_tdata, m_tlast,
    output at_valid, at_x_next, m_tready
  );

endinterface

// File: rtl/affine_iter_ctrl.sv
// Sequencer for the chaotic affine map x(n+1) = A*x(n) + U. Drives one
// affine_transform datapath with a single transaction in flight, throws away
// the warm-up iterations and streams the following cfg_count vectors out.
module affine_iter_ctrl #(
  parameter int unsigned PRECISION = 32,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [9*PRECISION-1:0] cfg_A,
  input  logic [3*PRECISION-1:0] cfg_U,
  input  logic [3*PRECISION-1:0] cfg_seed,
  input  logic [CNT_W-1:0]       cfg_warmup,
  input  logic [CNT_W-1:0]       cfg_count,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  affine_iter_ctrl_if.master     bus
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StEmit,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [9*PRECISION-1:0] a_q, a_d;
  logic [3*PRECISION-1:0] u_q, u_d;
  logic [3*PRECISION-1:0] x_q, x_d;
  logic [CNT_W-1:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0]       ocnt_q, ocnt_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [TW-1:0]          tcnt_inc;
  logic                   error_q, error_d;

  logic at_tvalid_q, at_tvalid_d;
  logic m_tvalid_q, m_tvalid_d;
  logic m_tlast_q, m_tlast_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic timeout_hit;

  assign tcnt_inc    = tcnt_q + 1'b1;
  assign timeout_hit = (tcnt_inc == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (cfg_count == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        if (bus.at_valid) begin
          state_d = (wcnt_q != '0) ? StIssue : StEmit;
        end else if (timeout_hit) begin
          state_d = StDone;
        end
      end
      StEmit: begin
        // m_tvalid is always high while in EMIT, so m_tready alone is the handshake
        if (bus.m_tready) begin
          state_d = (ocnt_q == CNT_W'(1)) ? StDone : StIssue;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (abort) begin
      state_d = StIdle;
    end
  end

  // Next values of configuration, iterate and counters
  always_comb begin
    a_d     = a_q;
    u_d     = u_q;
    x_d     = x_q;
    wcnt_d  = wcnt_q;
    ocnt_d  = ocnt_q;
    error_d = error_q;
    tcnt_d  = tcnt_q;
    // An abort freezes x and the latched configuration; late results are dropped
    if (!abort) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_d     = cfg_A;
            u_d     = cfg_U;
            x_d     = cfg_seed;
            wcnt_d  = cfg_warmup;
            ocnt_d  = cfg_count;
            error_d = 1'b0;
          end
        end
        StWait: begin
          if (bus.at_valid) begin
            x_d = bus.at_x_next;
            if (wcnt_q != '0) begin
              wcnt_d = wcnt_q - 1'b1;
            end
          end else if (timeout_hit) begin
            error_d = 1'b1;
          end
        end
        StEmit: begin
          if (bus.m_tready) begin
            ocnt_d = ocnt_q - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
    // Counter is zero in the ISSUE cycle and counts through ISSUE and WAIT
    if (state_d == StIssue) begin
      tcnt_d = '0;
    end else if (state_q == StIssue || state_q == StWait) begin
      tcnt_d = tcnt_inc;
    end
  end

  // Datapath register update
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      u_q     <= '0;
      x_q     <= '0;
      wcnt_q  <= '0;
      ocnt_q  <= '0;
      tcnt_q  <= '0;
      error_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      u_q     <= u_d;
      x_q     <= x_d;
      wcnt_q  <= wcnt_d;
      ocnt_q  <= ocnt_d;
      tcnt_q  <= tcnt_d;
      error_q <= error_d;
    end
  end

  // Output decode from the upcoming state, so each output is a flop
  always_comb begin
    at_tvalid_d = (state_d == StIssue);
    m_tvalid_d  = (state_d == StEmit);
    m_tlast_d   = (state_d == StEmit) && (ocnt_d == CNT_W'(1));
    busy_d      = (state_d != StIdle);
    // done trails the DONE state by one cycle; an abort there suppresses it
    done_d      = (state_q == StDone) && !abort;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      at_tvalid_q <= 1'b0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      at_tvalid_q <= at_tvalid_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.at_tvalid = at_tvalid_q;
  assign bus.at_A      = a_q;
  assign bus.at_U      = u_q;
  assign bus.at_x      = x_q;
  assign bus.m_tvalid  = m_tvalid_q;
  assign bus.m_tdata   = x_q;
  assign bus.m_tlast   = m_tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_affine_iter_ctrl.sv
// Bench for affine_iter_ctrl. The datapath stand-in computes a wrap-around
// integer affine map (the controller never looks at the numbers), and the
// scoreboard holds the vectors a run should emit, derived by iterating that map.
module tb_affine_iter_ctrl;

  localparam int unsigned P  = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned TO = 64;
  localparam int unsigned VW = 3 * P;
  localparam int unsigned AW = 9 * P;

  typedef struct {
    logic [VW-1:0] d;
    logic          last;
  } beat_t;

  typedef struct {
    int            due;
    logic [VW-1:0] d;
  } pend_t;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [AW-1:0] cfg_A;
  logic [VW-1:0] cfg_U, cfg_seed;
  logic [CW-1:0] cfg_warmup, cfg_count;
  logic          busy, done, error;

  affine_iter_ctrl_if #(.PRECISION(P)) bus ();

  affine_iter_ctrl #(
    .PRECISION(P),
    .CNT_W    (CW),
    .TIMEOUT  (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .cfg_A     (cfg_A),
    .cfg_U     (cfg_U),
    .cfg_seed  (cfg_seed),
    .cfg_warmup(cfg_warmup),
    .cfg_count (cfg_count),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  beat_t exp_q[$];
  pend_t pend_q[$];

  bit            dp_drop = 1'b0;
  int            dp_lat = 14;
  int            stray_cyc = -1;
  logic [VW-1:0] stray_data = '0;
  bit            ready_rand = 1'b0;
  bit            ready_hold = 1'b0;

  int tv_cnt = 0;
  bit tv_prev = 1'b0;
  int tv_last_cyc = 0;
  int tv_gap = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference map: x'[i] = U[i] + sum_j A[i][j]*x[j], all mod 2^32
  function automatic logic [VW-1:0] step(input logic [AW-1:0] a, input logic [VW-1:0] u,
                                         input logic [VW-1:0] x);
    logic [VW-1:0] r;
    logic [P-1:0]  acc;
    for (int i = 0; i < 3; i++) begin
      acc = u[i*P +: P];
      for (int j = 0; j < 3; j++) begin
        acc = acc + a[(3*i+j)*P +: P] * x[j*P +: P];
      end
      r[i*P +: P] = acc;
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < 3; i++) v[i*P +: P] = $urandom();
    return v;
  endfunction

  function automatic logic [AW-1:0] rand_mat();
    logic [AW-1:0] m;
    for (int i = 0; i < 9; i++) m[i*P +: P] = $urandom();
    return m;
  endfunction

  // Expected stream of a run: iterate warmup+count times, keep the last count
  task automatic push_run(input logic [AW-1:0] a, input logic [VW-1:0] u, input logic [VW-1:0] s,
                          input logic [CW-1:0] w, input logic [CW-1:0] c);
    logic [VW-1:0] x;
    beat_t         b;
    int            total;
    x = s;
    total = int'(w) + int'(c);
    for (int k = 0; k < total; k++) begin
      x = step(a, u, x);
      if (k >= int'(w)) begin
        b.d = x;
        b.last = (k == total - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  initial begin : cycle_counter
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Datapath stand-in: latch each issue, answer dp_lat cycles later
  initial begin : dp_capture
    pend_t p;
    forever begin
      @(negedge clk);
      if (bus.at_tvalid && !dp_drop) begin
        p.due = cyc + dp_lat;
        p.d = step(bus.at_A, bus.at_U, bus.at_x);
        pend_q.push_back(p);
      end
    end
  end

  initial begin : dp_drive
    bus.at_valid = 1'b0;
    bus.at_x_next = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.at_valid = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        bus.at_valid = 1'b1;
        bus.at_x_next = pend_q[0].d;
        void'(pend_q.pop_front());
      end else if (stray_cyc == cyc) begin
        bus.at_valid = 1'b1;
        bus.at_x_next = stray_data;
      end
    end
  end

  initial begin : ready_drive
    bus.m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_hold) bus.m_tready = 1'b0;
      else if (ready_rand) bus.m_tready = ($urandom_range(1, 0) == 1);
      else bus.m_tready = 1'b1;
    end
  end

  // Monitor: issue-pulse spacing, done events and scoreboard pops
  initial begin : monitor
    beat_t b;
    forever begin
      @(negedge clk);
      if (bus.at_tvalid) begin
        chk("tvalid_gap", VW'(tv_prev), '0);
        tv_gap = cyc - tv_last_cyc;
        tv_last_cyc = cyc;
        tv_cnt++;
      end
      tv_prev = bus.at_tvalid;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.m_tvalid && bus.m_tready) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", VW'(1), '0);
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", bus.m_tdata, b.d);
          chk("beat_last", VW'(bus.m_tlast), VW'(b.last));
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no summary expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] a, input logic [VW-1:0] u, input logic [VW-1:0] s,
                          input logic [CW-1:0] w, input logic [CW-1:0] c, input bit push,
                          output int k);
    to_pos();
    cfg_A = a;
    cfg_U = u;
    cfg_seed = s;
    cfg_warmup = w;
    cfg_count = c;
    start = 1'b1;
    k = cyc;
    if (push) push_run(a, u, s, w, c);
    to_pos();
    start = 1'b0;
    // Scrambled config after start must not leak into the run
    cfg_A = rand_mat();
    cfg_U = rand_vec();
    cfg_seed = rand_vec();
    cfg_warmup = CW'($urandom());
    cfg_count = CW'($urandom());
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      settle();
      n++;
    end
    if (done_cnt == d0) chk({tag, "_done_timeout"}, VW'(0), VW'(1));
  endtask

  initial begin : stimulus
    int            k, t0, d0, ic, w, c;
    logic [AW-1:0] a;
    logic [VW-1:0] u, s, xb, d_hold;
    bit            stable, seen;

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg_A = '0;
    cfg_U = '0;
    cfg_seed = '0;
    cfg_warmup = '0;
    cfg_count = '0;
    repeat (3) to_pos();
    settle();
    chk("rst_ctrl", VW'({busy, done, error, bus.at_tvalid, bus.m_tvalid, bus.m_tlast}), '0);
    chk("rst_at_A", VW'(bus.at_A != '0), '0);
    chk("rst_at_U", bus.at_U, '0);
    chk("rst_at_x", bus.at_x, '0);
    chk("rst_m_tdata", bus.m_tdata, '0);
    to_pos();
    reset = 1'b0;

    // Basic: A = 0 makes every result equal U
    dp_lat = 14;
    a = '0;
    u = {32'h40400000, 32'h40000000, 32'h3F800000};
    t0 = tv_cnt;
    do_start(a, u, '0, 16'd0, 16'd3, 1'b1, k);
    settle();
    chk("t1_first_issue", VW'(bus.at_tvalid), VW'(1));
    wait_done(400, "t1");
    chk("t1_pulses", VW'(tv_cnt - t0), VW'(3));
    chk("t1_period", VW'(tv_gap), VW'(16));
    chk("t1_last_data", bus.m_tdata, u);
    settle();
    chk("t1_done_width", VW'(done), '0);
    chk("t1_drained", VW'(exp_q.size()), '0);

    // Warm-up: identity A, U = 1 -> iterates 1,2,3,4; emits 3 then 4
    a = '0;
    a[0*P +: P] = 32'd1;
    a[4*P +: P] = 32'd1;
    a[8*P +: P] = 32'd1;
    u = {32'd1, 32'd1, 32'd1};
    t0 = tv_cnt;
    do_start(a, u, '0, 16'd2, 16'd2, 1'b1, k);
    wait_done(400, "t2");
    chk("t2_pulses", VW'(tv_cnt - t0), VW'(4));
    chk("t2_final_x", bus.m_tdata, {32'd4, 32'd4, 32'd4});

    // Backpressure with a stray result during EMIT
    ready_hold = 1'b1;
    do_start(rand_mat(), rand_vec(), rand_vec(), 16'd0, 16'd2, 1'b1, k);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      settle();
      seen = bus.m_tvalid;
    end
    chk("t3_valid_seen", VW'(seen), VW'(1));
    d_hold = bus.m_tdata;
    t0 = tv_cnt;
    stray_data = rand_vec();
    stray_cyc = cyc + 3;
    stable = 1'b1;
    repeat (10) begin
      settle();
      if (!bus.m_tvalid || bus.m_tdata !== d_hold) stable = 1'b0;
    end
    chk("t3_held_stable", VW'(stable), VW'(1));
    chk("t3_no_issue", VW'(tv_cnt - t0), '0);
    chk("t3_stray_ignored", bus.m_tdata, d_hold);
    stray_cyc = -1;
    ready_hold = 1'b0;
    wait_done(400, "t3");

    // Timeout: the datapath never answers
    dp_drop = 1'b1;
    do_start(rand_mat(), rand_vec(), rand_vec(), 16'd0, 16'd1, 1'b0, k);
    settle();
    ic = cyc;
    chk("t4_issue", VW'(bus.at_tvalid), VW'(1));
    wait_done(200, "t4");
    chk("t4_latency", VW'(done_cyc - ic), VW'(64));
    chk("t4_error", VW'(error), VW'(1));
    dp_drop = 1'b0;
    do_start(rand_mat(), rand_vec(), rand_vec(), 16'd0, 16'd1, 1'b1, k);
    settle();
    chk("t4_error_clear", VW'(error), '0);
    wait_done(400, "t4b");

    // cfg_count = 0
    t0 = tv_cnt;
    do_start(rand_mat(), rand_vec(), rand_vec(), 16'd5, 16'd0, 1'b1, k);
    wait_done(20, "t5");
    chk("t5_done_cycle", VW'(done_cyc - k), VW'(2));
    chk("t5_no_issue", VW'(tv_cnt - t0), '0);

    // start while busy is ignored
    t0 = tv_cnt;
    do_start(rand_mat(), rand_vec(), rand_vec(), 16'd1, 16'd2, 1'b1, k);
    repeat (4) settle();
    to_pos();
    cfg_count = 16'd5;
    start = 1'b1;
    to_pos();
    start = 1'b0;
    wait_done(400, "t6");
    chk("t6_pulses", VW'(tv_cnt - t0), VW'(3));
    repeat (3) settle();
    chk("t6_idle", VW'(busy), '0);

    // Abort mid-WAIT, then a clean run
    do_start(rand_mat(), rand_vec(), rand_vec(), 16'd0, 16'd2, 1'b1, k);
    repeat (4) settle();
    to_pos();
    abort = 1'b1;
    xb = bus.at_x;
    d0 = done_cnt;
    t0 = tv_cnt;
    exp_q.delete();
    to_pos();
    abort = 1'b0;
    settle();
    chk("t7_abort_ctrl", VW'({busy, bus.m_tvalid, bus.at_tvalid}), '0);
    repeat (25) settle();
    chk("t7_late_ignored", bus.at_x, xb);
    chk("t7_no_done", VW'(done_cnt - d0), '0);
    chk("t7_no_issue", VW'(tv_cnt - t0), '0);
    do_start(rand_mat(), rand_vec(), rand_vec(), 16'd1, 16'd2, 1'b1, k);
    wait_done(400, "t7b");

    // Reset mid-WAIT, then a clean run
    do_start(rand_mat(), rand_vec(), rand_vec(), 16'd0, 16'd2, 1'b1, k);
    repeat (4) settle();
    to_pos();
    reset = 1'b1;
    d0 = done_cnt;
    exp_q.delete();
    to_pos();
    reset = 1'b0;
    settle();
    chk("t8_rst_ctrl", VW'({busy, done, error, bus.at_tvalid, bus.m_tvalid, bus.m_tlast}), '0);
    chk("t8_rst_at_A", VW'(bus.at_A != '0), '0);
    chk("t8_rst_at_U", bus.at_U, '0);
    chk("t8_rst_at_x", bus.at_x, '0);
    repeat (25) settle();
    chk("t8_late_ignored", bus.at_x, '0);
    chk("t8_no_done", VW'(done_cnt - d0), '0);
    do_start(rand_mat(), rand_vec(), rand_vec(), 16'd2, 16'd1, 1'b1, k);
    wait_done(400, "t8b");

    // Randomised runs with random downstream readiness
    ready_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      dp_lat = $urandom_range(20, 2);
      w = $urandom_range(3, 0);
      c = $urandom_range(4, 1);
      t0 = tv_cnt;
      do_start(rand_mat(), rand_vec(), rand_vec(), CW'(w), CW'(c), 1'b1, k);
      wait_done(3000, "rnd");
      chk("rnd_pulses", VW'(tv_cnt - t0), VW'(w + c));
    end
    ready_rand = 1'b0;

    repeat (3) settle();
    chk("sb_drained", VW'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
